bcd_grant_dispatcher: RTL and testbench
=======================================

// Module: bcd_grant_dispatcher
// PURPOSE
//  Consumer side of the binary-coded arbiter grant. Takes grant/any_grant from an
//  arbiter, decodes the index to a registered one-hot grant and mux select, and
//  locks the path to the winner until its tail flit transfers. Sits between the
//  VC/switch allocator and the crossbar in each mesh router output port.
//  Includes a stall watchdog that force-releases a lock that makes no progress.
// PARAMETERS
//  ARBITER_WIDTH      4    number of requesters (ports/VCs)
//  ARBITER_BCD_WIDTH  log2(ARBITER_WIDTH)  width of binary grant index
//  MAX_STALL          255  consecutive no-transfer LOCKED cycles before forced release
//  STALL_CNT_WIDTH    log2(MAX_STALL+1)  stall counter width
// PORTS
//  clk            in   1                  rising-edge clock
//  reset          in   1                  synchronous, active-high
//  grant_bcd      in   ARBITER_BCD_WIDTH  winner index from arbiter
//  any_grant_in   in   1                  grant_bcd is valid this cycle
//  flit_valid     in   ARBITER_WIDTH      per-requester flit present
//  tail_flit      in   ARBITER_WIDTH      per-requester current flit is tail
//  out_ready      in   1                  downstream accepts a flit this cycle
//  grant_onehot   out  ARBITER_WIDTH      registered one-hot grant (crossbar enable)
//  mux_sel        out  ARBITER_BCD_WIDTH  registered winner index (crossbar select)
//  locked         out  1                  path held; arbiter must mask requests
//  flit_fire      out  1                  comb: flit_valid[mux_sel] & out_ready & locked
//  timeout_err    out  1                  one-cycle pulse on forced release
//  invalid_err    out  1                  one-cycle pulse on out-of-range grant_bcd
// BEHAVIOUR
//  Reset: state=IDLE; grant_onehot=0, mux_sel=0, locked=0, stall_cnt=0,
//   timeout_err=0, invalid_err=0. Reset wins over every other event.
//  IDLE: if any_grant_in & grant_bcd<ARBITER_WIDTH -> capture index, go LOCKED;
//   grant_onehot/mux_sel/locked valid the next cycle (1-cycle latency).
//   If any_grant_in & grant_bcd>=ARBITER_WIDTH (non-power-of-2 widths): stay IDLE,
//   pulse invalid_err next cycle, outputs unchanged. any_grant_in=0: stay IDLE.
//  LOCKED: grant_bcd/any_grant_in ignored. grant_onehot and mux_sel stable.
//   flit_fire & tail_flit[mux_sel] -> IDLE next cycle; grant_onehot=0, locked=0.
//   flit_fire & !tail -> stay, stall_cnt<=0.
//   !flit_fire -> stall_cnt+1; when stall_cnt==MAX_STALL-1 and still no transfer,
//   go IDLE, clear grant, pulse timeout_err; stall_cnt<=0.
//   Tail transfer and watchdog expiry in same cycle: tail wins, no timeout_err.
//  Back-to-back packets: one IDLE bubble after release; earliest re-lock is
//   the edge after the release edge (single-flit packet = 2 cycles/packet min).
//  stall_cnt saturates never beyond MAX_STALL-1; cleared on entering LOCKED.
//  Single-flit packet (head==tail): released on its first transfer.
//  Invariant: grant_onehot is zero or exactly one-hot; ==(1<<mux_sel) when locked.
// STRUCTURE
//  States IDLE/LOCKED encoding and `LOG2 macro come from define.v (shared header).
//  One sub-module: bcd_to_onehot (combinational index->one-hot decode,
//   parameter ARBITER_WIDTH); output register and FSM live in this module.
// TESTING
//  Reset held 3 cycles with any_grant_in=1 -> all outputs 0, no lock.
//  W=4: grant_bcd=2, any_grant=1 at cycle 0 -> cycle 1 grant_onehot=4'b0100,
//   mux_sel=2, locked=1; 3 flits on port 2 with out_ready=1, tail on 3rd ->
//   flit_fire 3 cycles, locked=0 the cycle after tail.
//  While locked to 2, drive grant_bcd=1 any_grant=1 -> grant_onehot stays 4'b0100.
//  MAX_STALL=4, locked, out_ready=0 -> forced release after 4 cycles, timeout_err
//   single pulse, grant_onehot=0; tail on 4th cycle instead -> no timeout_err.
//  W=5 (BCD width 3): grant_bcd=6 -> invalid_err pulse, stays IDLE.
//  reset asserted mid-packet while LOCKED -> next cycle IDLE, all outputs 0.

Source files
------------

// File: rtl/bcd_grant_dispatcher_pkg.sv
// Shared types and helpers for the grant dispatcher: FSM state encoding and
// index-width derivation used by the top and the decoder.
package bcd_grant_dispatcher_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Width of a binary index able to address n entries; never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_grant_dispatcher_bcd_to_onehot.sv
// Combinational binary-index to one-hot decoder. valid is low when the index
// addresses no requester (only possible for non-power-of-two widths).
module bcd_to_onehot
    import bcd_grant_dispatcher_pkg::*;
#(
    parameter int ARBITER_WIDTH     = 4,
    parameter int ARBITER_BCD_WIDTH = idx_width(ARBITER_WIDTH)
) (
    input  logic [ARBITER_BCD_WIDTH-1:0] bcd,
    output logic [ARBITER_WIDTH-1:0]     onehot,
    output logic                         valid
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < ARBITER_WIDTH; i++) begin
            onehot[i] = (bcd == ARBITER_BCD_WIDTH'(i));
        end
    end

    assign valid = |onehot;

endmodule

// File: rtl/bcd_grant_dispatcher.sv
// Grant dispatcher: registers the arbiter's binary grant as a one-hot crossbar
// enable, holds the path until the winner's tail flit moves, and force-releases
// a lock that stalls for MAX_STALL consecutive cycles.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_IDLE   | no path held; accept a valid grant, flag out-of-range index
//  ST_LOCKED | path held for mux_sel; wait for tail transfer or watchdog
module bcd_grant_dispatcher
    import bcd_grant_dispatcher_pkg::*;
#(
    parameter int ARBITER_WIDTH     = 4,
    parameter int ARBITER_BCD_WIDTH = idx_width(ARBITER_WIDTH),
    parameter int MAX_STALL         = 255,
    parameter int STALL_CNT_WIDTH   = idx_width(MAX_STALL + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ARBITER_BCD_WIDTH-1:0] grant_bcd,
    input  logic                         any_grant_in,
    input  logic [ARBITER_WIDTH-1:0]     flit_valid,
    input  logic [ARBITER_WIDTH-1:0]     tail_flit,
    input  logic                         out_ready,
    output logic [ARBITER_WIDTH-1:0]     grant_onehot,
    output logic [ARBITER_BCD_WIDTH-1:0] mux_sel,
    output logic                         locked,
    output logic                         flit_fire,
    output logic                         timeout_err,
    output logic                         invalid_err
);

    localparam logic [STALL_CNT_WIDTH-1:0] STALL_LAST = STALL_CNT_WIDTH'(MAX_STALL - 1);

    state_t                     state;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt;
    logic [ARBITER_WIDTH-1:0]   dec_onehot;
    logic                       dec_valid;
    logic                       tail_sel;

    bcd_to_onehot #(
        .ARBITER_WIDTH    (ARBITER_WIDTH),
        .ARBITER_BCD_WIDTH(ARBITER_BCD_WIDTH)
    ) u_bcd_to_onehot (
        .bcd   (grant_bcd),
        .onehot(dec_onehot),
        .valid (dec_valid)
    );

    assign locked    = (state == ST_LOCKED);
    assign flit_fire = flit_valid[mux_sel] & out_ready & locked;
    assign tail_sel  = tail_flit[mux_sel];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            grant_onehot <= '0;
            mux_sel      <= '0;
            stall_cnt    <= '0;
            timeout_err  <= 1'b0;
            invalid_err  <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            invalid_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_grant_in) begin
                        if (dec_valid) begin
                            state        <= ST_LOCKED;
                            grant_onehot <= dec_onehot;
                            mux_sel      <= grant_bcd;
                            stall_cnt    <= '0;
                        end else begin
                            invalid_err <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    // A tail transfer takes priority over a coincident watchdog expiry.
                    if (flit_fire) begin
                        stall_cnt <= '0;
                        if (tail_sel) begin
                            state        <= ST_IDLE;
                            grant_onehot <= '0;
                        end
                    end else if (stall_cnt == STALL_LAST) begin
                        state        <= ST_IDLE;
                        grant_onehot <= '0;
                        timeout_err  <= 1'b1;
                        stall_cnt    <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_grant_dispatcher.sv
// Bench for bcd_grant_dispatcher: a directed vector table and hand sequences,
// plus random traffic on a W=4 and a W=5 instance checked against a packet-level model.
module tb_bcd_grant_dispatcher;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       any = 1'b1;
    logic [2:0] bcd = 3'd2;
    logic [4:0] fv = '0;
    logic [4:0] tl = '0;
    logic       rdy = 1'b0;

    logic [3:0] oh4;  logic [1:0] sel4; logic lk4, ff4, to4, iv4;
    logic [4:0] oh5;  logic [2:0] sel5; logic lk5, ff5, to5, iv5;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    bcd_grant_dispatcher #(.ARBITER_WIDTH(4), .MAX_STALL(4)) dut4 (
        .clk(clk), .reset(reset), .grant_bcd(bcd[1:0]), .any_grant_in(any),
        .flit_valid(fv[3:0]), .tail_flit(tl[3:0]), .out_ready(rdy),
        .grant_onehot(oh4), .mux_sel(sel4), .locked(lk4), .flit_fire(ff4),
        .timeout_err(to4), .invalid_err(iv4));

    bcd_grant_dispatcher #(.ARBITER_WIDTH(5), .MAX_STALL(6)) dut5 (
        .clk(clk), .reset(reset), .grant_bcd(bcd), .any_grant_in(any),
        .flit_valid(fv), .tail_flit(tl), .out_ready(rdy),
        .grant_onehot(oh5), .mux_sel(sel5), .locked(lk5), .flit_fire(ff5),
        .timeout_err(to5), .invalid_err(iv5));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Packet-level reference: who owns the output, how long it has waited, pending pulses.
    int width_of[2] = '{4, 5};
    int stall_of[2] = '{4, 6};
    bit busy[2];
    int owner[2];
    int waited[2];
    bit tmo[2];
    bit inv[2];

    always @(negedge clk) begin
        if (model_on) begin
            for (int d = 0; d < 2; d++) begin
                logic [4:0] e_oh;
                logic [4:0] a_oh;
                logic [2:0] a_sel;
                logic a_lk, a_ff, a_to, a_iv;
                bit moved;
                int b;
                e_oh  = busy[d] ? 5'(1 << owner[d]) : 5'd0;
                a_oh  = (d == 0) ? {1'b0, oh4} : oh5;
                a_sel = (d == 0) ? {1'b0, sel4} : sel5;
                a_lk  = (d == 0) ? lk4 : lk5;
                a_ff  = (d == 0) ? ff4 : ff5;
                a_to  = (d == 0) ? to4 : to5;
                a_iv  = (d == 0) ? iv4 : iv5;
                moved = busy[d] && fv[owner[d]] && rdy;
                chk($sformatf("model%0d grant_onehot", d), 32'(a_oh), 32'(e_oh));
                chk($sformatf("model%0d mux_sel", d), 32'(a_sel), 32'(owner[d]));
                chk($sformatf("model%0d locked", d), 32'(a_lk), 32'(busy[d]));
                chk($sformatf("model%0d flit_fire", d), 32'(a_ff), 32'(moved));
                chk($sformatf("model%0d timeout_err", d), 32'(a_to), 32'(tmo[d]));
                chk($sformatf("model%0d invalid_err", d), 32'(a_iv), 32'(inv[d]));

                b = (d == 0) ? int'(bcd[1:0]) : int'(bcd);
                tmo[d] = 1'b0;
                inv[d] = 1'b0;
                if (reset) begin
                    busy[d] = 1'b0; owner[d] = 0; waited[d] = 0;
                end else if (!busy[d]) begin
                    if (any) begin
                        if (b < width_of[d]) begin
                            busy[d] = 1'b1; owner[d] = b; waited[d] = 0;
                        end else begin
                            inv[d] = 1'b1;
                        end
                    end
                end else if (moved) begin
                    waited[d] = 0;
                    if (tl[owner[d]]) busy[d] = 1'b0;
                end else if (waited[d] + 1 == stall_of[d]) begin
                    busy[d] = 1'b0; tmo[d] = 1'b1; waited[d] = 0;
                end else begin
                    waited[d]++;
                end
            end
        end
    end

    typedef struct {
        bit       rst; bit any; bit [2:0] bcd; bit [4:0] fv; bit [4:0] tl; bit rdy;
        bit [3:0] e_oh; bit [1:0] e_sel; bit e_lk; bit e_ff; bit e_to;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(bit r, bit a, bit [2:0] g, bit [4:0] f, bit [4:0] t, bit y,
                                bit [3:0] oh, bit [1:0] s, bit lk, bit ff, bit to);
        vec_t v;
        v.rst = r; v.any = a; v.bcd = g; v.fv = f; v.tl = t; v.rdy = y;
        v.e_oh = oh; v.e_sel = s; v.e_lk = lk; v.e_ff = ff; v.e_to = to;
        return v;
    endfunction

    task automatic drive(input bit r, input bit a, input bit [2:0] g,
                         input bit [4:0] f, input bit [4:0] t, input bit y);
        reset = r; any = a; bcd = g; fv = f; tl = t; rdy = y;
    endtask

    initial begin
        //            rst any bcd  fv        tl        rdy  oh       sel lk ff to
        tv.push_back(mk(1, 1, 2, 5'b00000, 5'b00000, 0, 4'b0000, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 2, 5'b00100, 5'b00000, 1, 4'b0000, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 2, 5'b00000, 5'b00000, 0, 4'b0000, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 2, 5'b00000, 5'b00000, 0, 4'b0000, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 5'b00100, 5'b00000, 1, 4'b0100, 2, 1, 1, 0));
        tv.push_back(mk(0, 1, 1, 5'b00100, 5'b00000, 1, 4'b0100, 2, 1, 1, 0));
        tv.push_back(mk(0, 0, 0, 5'b00100, 5'b00100, 1, 4'b0100, 2, 1, 1, 0));
        tv.push_back(mk(0, 0, 0, 5'b00000, 5'b00000, 1, 4'b0000, 2, 0, 0, 0));
        tv.push_back(mk(0, 1, 3, 5'b00000, 5'b00000, 0, 4'b0000, 2, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 5'b01000, 5'b00000, 0, 4'b1000, 3, 1, 0, 0));
        tv.push_back(mk(0, 1, 1, 5'b01000, 5'b00000, 0, 4'b1000, 3, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 5'b01000, 5'b00000, 0, 4'b1000, 3, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 5'b01000, 5'b00000, 0, 4'b1000, 3, 1, 0, 0));
        tv.push_back(mk(0, 1, 0, 5'b00000, 5'b00000, 0, 4'b0000, 3, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 5'b00001, 5'b00000, 0, 4'b0001, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 5'b00001, 5'b00000, 0, 4'b0001, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 5'b00001, 5'b00000, 0, 4'b0001, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 5'b00001, 5'b00001, 1, 4'b0001, 0, 1, 1, 0));
        tv.push_back(mk(0, 1, 1, 5'b00000, 5'b00000, 0, 4'b0000, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 2, 5'b00010, 5'b00010, 1, 4'b0010, 1, 1, 1, 0));
        tv.push_back(mk(0, 1, 2, 5'b00000, 5'b00000, 0, 4'b0000, 1, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 5'b00100, 5'b00000, 0, 4'b0100, 2, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 5'b00000, 5'b00000, 0, 4'b0000, 0, 0, 0, 0));

        @(posedge clk); #1;
        model_on = 1'b1;

        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].any, tv[i].bcd, tv[i].fv, tv[i].tl, tv[i].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d grant_onehot", i), 32'(oh4), 32'(tv[i].e_oh));
            chk($sformatf("vec%0d mux_sel", i), 32'(sel4), 32'(tv[i].e_sel));
            chk($sformatf("vec%0d locked", i), 32'(lk4), 32'(tv[i].e_lk));
            chk($sformatf("vec%0d flit_fire", i), 32'(ff4), 32'(tv[i].e_ff));
            chk($sformatf("vec%0d timeout_err", i), 32'(to4), 32'(tv[i].e_to));
            chk($sformatf("vec%0d invalid_err", i), 32'(iv4), 32'd0);
            @(posedge clk); #1;
        end

        // W=5: out-of-range index pulses invalid_err once and leaves the path idle.
        drive(0, 1, 6, 5'b00000, 5'b00000, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 5'b00000, 5'b00000, 0);
        @(negedge clk);
        chk("w5 invalid pulse", 32'(iv5), 32'd1);
        chk("w5 invalid stays idle", 32'(lk5), 32'd0);
        chk("w5 invalid no grant", 32'(oh5), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w5 invalid single pulse", 32'(iv5), 32'd0);

        // W=5: highest legal index locks onto requester 4.
        drive(1, 0, 0, 5'b00000, 5'b00000, 0);
        @(posedge clk); #1;
        drive(0, 1, 4, 5'b00000, 5'b00000, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 5'b10000, 5'b10000, 1);
        @(negedge clk);
        chk("w5 top grant_onehot", 32'(oh5), 32'h10);
        chk("w5 top mux_sel", 32'(sel5), 32'd4);
        chk("w5 top flit_fire", 32'(ff5), 32'd1);
        chk("w5 top invalid", 32'(iv5), 32'd0);
        @(posedge clk); #1;

        for (int c = 0; c < 4000; c++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
                  3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom & $urandom),
                  ($urandom_range(0, 9) < 6));
            @(posedge clk); #1;
        end
        drive(1, 0, 0, 5'b00000, 5'b00000, 0);
        @(posedge clk); #1;
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
